// File: rtl/disp_scan_driver.sv
// Two-digit common-anode 7-segment scan driver: captures a 14-bit segment word and
// time-multiplexes it onto a shared bus. Latency: outputs registered, one cycle behind scan state.
// Backpressure: none; Load_in is accepted on every non-reset cycle.
module disp_scan_driver #(
    parameter int REFRESH_DIV    = 4096,
    parameter int GAP_CYCLES     = 16,
    parameter int BLINK_DIV      = 32,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit DIG_ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [13:0] Disp_in,
    input  logic        Load_in,
    input  logic        Blank_in,
    input  logic        Blink_en_in,
    output logic [6:0]  Seg_out,
    output logic [1:0]  Dig_out,
    output logic        Frame_out
);

    localparam int MAX_LEN = (REFRESH_DIV > GAP_CYCLES) ? REFRESH_DIV : GAP_CYCLES;
    localparam int CW      = $clog2(MAX_LEN) + 1;
    localparam int FW      = $clog2(BLINK_DIV) + 1;

    localparam logic [CW-1:0] REF_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);
    localparam logic [FW-1:0] FRM_LAST = FW'(BLINK_DIV - 1);
    localparam logic [6:0]    SEG_OFF  = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [1:0]    DIG_OFF  = DIG_ACTIVE_LOW ? 2'b11 : 2'b00;

    typedef enum logic [1:0] {
        S_RIGHT  = 2'd0,
        S_GAP_RL = 2'd1,
        S_LEFT   = 2'd2,
        S_GAP_LR = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [FW-1:0] frame_cnt_q, frame_cnt_d;
    logic          phase_q, phase_d;
    logic          pend_q, pend_d;
    logic [13:0]   disp_q, disp_d;
    logic [6:0]    seg_q, seg_d;
    logic [1:0]    dig_q, dig_d;
    logic          frame_q, frame_d;

    logic          slot_last;
    logic          wrap;
    logic [6:0]    seg_on;
    logic [1:0]    dig_on;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + CW'(1);
        frame_cnt_d = frame_cnt_q;
        phase_d     = phase_q;
        disp_d      = Load_in ? Disp_in : disp_q;
        seg_on      = 7'h00;
        dig_on      = 2'b00;

        if ((state_q == S_RIGHT) || (state_q == S_LEFT)) begin
            slot_last = (cnt_q == REF_LAST);
        end else begin
            slot_last = (cnt_q == GAP_LAST);
        end

        if (slot_last) begin
            cnt_d = '0;
            case (state_q)
                S_RIGHT:  state_d = S_GAP_RL;
                S_GAP_RL: state_d = S_LEFT;
                S_LEFT:   state_d = S_GAP_LR;
                default:  state_d = S_RIGHT;
            endcase
        end

        // A frame completes when the left-to-right gap hands back to the right digit.
        wrap   = (state_q == S_GAP_LR) && slot_last;
        pend_d = wrap;
        if (wrap) begin
            if (frame_cnt_q == FRM_LAST) begin
                frame_cnt_d = '0;
                phase_d     = ~phase_q;
            end else begin
                frame_cnt_d = frame_cnt_q + FW'(1);
            end
        end

        case (state_q)
            S_RIGHT: begin
                seg_on = disp_q[6:0];
                dig_on = 2'b01;
            end
            S_LEFT: begin
                seg_on = disp_q[13:7];
                dig_on = 2'b10;
            end
            default: begin
                seg_on = 7'h00;
                dig_on = 2'b00;
            end
        endcase

        if (Blank_in || (Blink_en_in && phase_q)) begin
            seg_on = 7'h00;
            dig_on = 2'b00;
        end

        seg_d   = seg_on ^ {7{SEG_ACTIVE_LOW}};
        dig_d   = dig_on ^ {2{DIG_ACTIVE_LOW}};
        frame_d = pend_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_RIGHT;
            cnt_q       <= '0;
            frame_cnt_q <= '0;
            phase_q     <= 1'b0;
            pend_q      <= 1'b0;
            disp_q      <= '0;
            seg_q       <= SEG_OFF;
            dig_q       <= DIG_OFF;
            frame_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            frame_cnt_q <= frame_cnt_d;
            phase_q     <= phase_d;
            pend_q      <= pend_d;
            disp_q      <= disp_d;
            seg_q       <= seg_d;
            dig_q       <= dig_d;
            frame_q     <= frame_d;
        end
    end

    assign Seg_out   = seg_q;
    assign Dig_out   = dig_q;
    assign Frame_out = frame_q;

endmodule

// File: tb/tb_disp_scan_driver.sv
// Bench for disp_scan_driver with a small frame-position reference model feeding a scoreboard,
// a constant vector table for reset/scan order, and hand sequences for blink, blank and reset.
module tb_disp_scan_driver;

    localparam int R  = 4;
    localparam int G  = 1;
    localparam int B  = 2;
    localparam int FR = 2 * (R + G);

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [13:0] disp = '0;
    logic        load = 1'b0;
    logic        blank = 1'b0;
    logic        blink = 1'b0;
    logic [6:0]  Seg_out;
    logic [1:0]  Dig_out;
    logic        Frame_out;

    disp_scan_driver #(
        .REFRESH_DIV(R),
        .GAP_CYCLES(G),
        .BLINK_DIV(B),
        .SEG_ACTIVE_LOW(1'b1),
        .DIG_ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .Disp_in(disp),
        .Load_in(load),
        .Blank_in(blank),
        .Blink_en_in(blink),
        .Seg_out(Seg_out),
        .Dig_out(Dig_out),
        .Frame_out(Frame_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] seg;
        logic [1:0] dig;
        logic       frame;
    } exp_t;

    typedef struct {
        logic        rst_n;
        logic        load;
        logic [13:0] disp;
        logic [6:0]  seg;
        logic [1:0]  dig;
        logic        frame;
    } vec_t;

    exp_t exp_q[$];
    vec_t tbl[$];

    int chk_cnt  = 0;
    int pass_cnt = 0;

    // Reference model: position within the frame rather than an explicit state machine.
    int          m_pos = 0;
    int          m_fcnt = 0;
    bit          m_phase = 1'b0;
    bit          m_started = 1'b0;
    logic [13:0] m_dreg = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        exp_t       e;
        exp_t       got;
        logic [6:0] on;
        logic [1:0] d;
        on = 7'h00;
        d  = 2'b00;
        if (!rst_n) begin
            e = '{7'h7F, 2'b11, 1'b0};
            m_pos = 0; m_fcnt = 0; m_phase = 1'b0; m_started = 1'b0; m_dreg = '0;
        end else begin
            if (m_pos < R) begin
                on = m_dreg[6:0];  d = 2'b01;
            end else if ((m_pos >= R + G) && (m_pos < 2 * R + G)) begin
                on = m_dreg[13:7]; d = 2'b10;
            end
            if (blank || (blink && m_phase)) begin
                on = 7'h00; d = 2'b00;
            end
            e.seg   = ~on;
            e.dig   = ~d;
            e.frame = (m_pos == 0) && m_started;
            if (load) m_dreg = disp;
            if (m_pos == FR - 1) begin
                m_pos = 0;
                m_started = 1'b1;
                m_fcnt++;
                if (m_fcnt == B) begin
                    m_fcnt  = 0;
                    m_phase = ~m_phase;
                end
            end else begin
                m_pos++;
            end
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            chk_cnt++;
            $display("FAIL sb_empty: got no entry expected one");
        end else begin
            got = exp_q.pop_front();
            chk("sb", {22'd0, Seg_out, Dig_out, Frame_out}, {22'd0, got.seg, got.dig, got.frame});
        end
    endtask

    function automatic vec_t mk(input logic r, input logic l, input logic [13:0] dv,
                                input logic [6:0] s, input logic [1:0] dg, input logic f);
        vec_t v;
        v.rst_n = r; v.load = l; v.disp = dv; v.seg = s; v.dig = dg; v.frame = f;
        return v;
    endfunction

    initial begin
        int last_frame;
        int bad_dig;
        int lit;
        int pulses;
        int n;

        for (int i = 0; i < 3; i++) tbl.push_back(mk(1'b0, 1'b0, 14'h0, 7'h7F, 2'b11, 1'b0));
        for (int i = 0; i < 4; i++) tbl.push_back(mk(1'b1, 1'b0, 14'h0, 7'h7F, 2'b10, 1'b0));
        tbl.push_back(mk(1'b1, 1'b0, 14'h0, 7'h7F, 2'b11, 1'b0));
        for (int i = 0; i < 4; i++) tbl.push_back(mk(1'b1, 1'b0, 14'h0, 7'h7F, 2'b01, 1'b0));
        tbl.push_back(mk(1'b1, 1'b1, {7'h30, 7'h6D}, 7'h7F, 2'b11, 1'b0));
        tbl.push_back(mk(1'b1, 1'b0, 14'h0, 7'h12, 2'b10, 1'b1));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(1'b1, 1'b0, 14'h0, 7'h12, 2'b10, 1'b0));
        tbl.push_back(mk(1'b1, 1'b0, 14'h0, 7'h7F, 2'b11, 1'b0));
        for (int i = 0; i < 4; i++) tbl.push_back(mk(1'b1, 1'b0, 14'h0, 7'h4F, 2'b01, 1'b0));
        tbl.push_back(mk(1'b1, 1'b0, 14'h0, 7'h7F, 2'b11, 1'b0));
        tbl.push_back(mk(1'b1, 1'b0, 14'h0, 7'h12, 2'b10, 1'b1));

        foreach (tbl[i]) begin
            rst_n = tbl[i].rst_n;
            load  = tbl[i].load;
            disp  = tbl[i].disp;
            tick();
            chk($sformatf("vec%0d", i), {22'd0, Seg_out, Dig_out, Frame_out},
                {22'd0, tbl[i].seg, tbl[i].dig, tbl[i].frame});
        end
        load = 1'b0;

        // Free run: frame pulse spacing and never two digits on at once.
        last_frame = -1;
        bad_dig    = 0;
        for (int c = 0; c < 50; c++) begin
            tick();
            if (Dig_out == 2'b00) bad_dig++;
            if (Frame_out) begin
                if (last_frame >= 0) chk("frame_period", c - last_frame, FR);
                last_frame = c;
            end
        end
        chk("dig_never_00", bad_dig, 0);

        // Blink over four whole frames: two lit, two dark, pulses continue.
        blink = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!Frame_out && n < 2 * FR);
        chk("blink_sync", Frame_out, 1'b1);
        lit    = (Dig_out != 2'b11) ? 1 : 0;
        pulses = 1;
        for (int c = 1; c < 4 * FR; c++) begin
            if (c == 15) begin
                load = 1'b1;
                disp = {7'h06, 7'h5B};
            end
            tick();
            load = 1'b0;
            if (Dig_out != 2'b11) lit++;
            if (Frame_out) pulses++;
        end
        chk("blink_lit_cycles", lit, 2 * 2 * R);
        chk("blink_pulses", pulses, 4);
        blink = 1'b0;

        // Blank two cycles from left-slot count 1, with a load landing during blank.
        n = 0;
        while (m_pos != R + G + 1 && n < 2 * FR) begin
            tick();
            n++;
        end
        chk("blank_sync", m_pos, R + G + 1);
        blank = 1'b1;
        load  = 1'b1;
        disp  = {7'h30, 7'h6D};
        tick();
        chk("blank_c1", {23'd0, Seg_out, Dig_out}, {23'd0, 7'h7F, 2'b11});
        load = 1'b0;
        tick();
        chk("blank_c2", {23'd0, Seg_out, Dig_out}, {23'd0, 7'h7F, 2'b11});
        blank = 1'b0;
        tick();
        chk("blank_release", {23'd0, Seg_out, Dig_out}, {23'd0, 7'h4F, 2'b01});
        tick();
        chk("blank_gap", {23'd0, Seg_out, Dig_out}, {23'd0, 7'h7F, 2'b11});

        // Reset mid left slot while loading all-ones: data must not be captured.
        n = 0;
        while (m_pos != R + G + 2 && n < 2 * FR) begin
            tick();
            n++;
        end
        chk("rst_sync", m_pos, R + G + 2);
        rst_n = 1'b0;
        load  = 1'b1;
        disp  = 14'h3FFF;
        tick();
        chk("rst_mid", {22'd0, Seg_out, Dig_out, Frame_out}, {22'd0, 7'h7F, 2'b11, 1'b0});
        tick();
        load  = 1'b0;
        rst_n = 1'b1;
        for (int c = 0; c < R; c++) begin
            tick();
            chk($sformatf("rst_right%0d", c), {22'd0, Seg_out, Dig_out, Frame_out},
                {22'd0, 7'h7F, 2'b10, 1'b0});
        end
        tick();
        chk("rst_gap", {23'd0, Seg_out, Dig_out}, {23'd0, 7'h7F, 2'b11});

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
